// File: rtl/hazard_ctrl_pkg.sv
// Shared RV32I pipeline types: register index and hazard-controller FSM state.
// No logic; types only.
// No flow control.
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    // Hazard-controller state. It lives here beside the other pipeline enums.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        MSTALL = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W.
// Count is visible one cycle after the inc cycle.
// No backpressure; inc is sampled every cycle.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory stalls, branch flushes, load-use bubbles, perf counters.
// Zero-cycle latency: all enables are combinational from inputs and done flags.
// A memory miss freezes every stage; done flags mask responses already received.
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  rv32i_reg         ID_rs1_i,
    input  rv32i_reg         ID_rs2_i,
    input  logic             ID_use_rs1_i,
    input  logic             ID_use_rs2_i,
    input  rv32i_reg         EX_rd_i,
    input  logic             EX_mem_read_i,
    input  logic             EX_br_taken_i,
    input  logic             imem_read_i,
    input  logic             imem_resp_i,
    input  logic             dmem_req_i,
    input  logic             dmem_resp_i,
    output logic             pc_load_o,
    output logic             IF_ID_load_o,
    output logic             ID_EX_load_o,
    output logic             EX_MEM_load_o,
    output logic             MEM_WB_load_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             imem_capture_o,
    output logic             imem_mask_o,
    output logic             dmem_mask_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    hazard_state_t state_q, state_d;
    logic imem_done_q, imem_done_d;
    logic dmem_done_q, dmem_done_d;
    logic imem_busy, dmem_busy, mstall;
    logic rs1_hit, rs2_hit, load_use;
    logic do_flush, do_bubble;

    always_comb begin
        imem_busy = imem_read_i & ~imem_resp_i & ~imem_done_q;
        dmem_busy = dmem_req_i & ~dmem_resp_i & ~dmem_done_q;
        mstall    = imem_busy | dmem_busy;

        rs1_hit  = ID_use_rs1_i & (EX_rd_i == ID_rs1_i);
        rs2_hit  = ID_use_rs2_i & (EX_rd_i == ID_rs2_i);
        load_use = EX_mem_read_i & (|EX_rd_i) & (rs1_hit | rs2_hit);

        // A taken branch kills the dependent ID instruction, so it outranks load-use.
        do_flush  = ~mstall & EX_br_taken_i;
        do_bubble = ~mstall & ~EX_br_taken_i & load_use;

        pc_load_o     = ~mstall & ~do_bubble;
        IF_ID_load_o  = ~mstall & ~do_bubble;
        ID_EX_load_o  = ~mstall;
        EX_MEM_load_o = ~mstall;
        MEM_WB_load_o = ~mstall;
        IF_ID_flush_o = do_flush;
        ID_EX_flush_o = do_flush | do_bubble;

        imem_capture_o = mstall & imem_resp_i;
        imem_mask_o    = imem_done_q;
        dmem_mask_o    = dmem_done_q;

        // Flags remember a response that came back while the other side still stalls.
        imem_done_d = mstall ? (imem_done_q | imem_resp_i) : 1'b0;
        dmem_done_d = mstall ? (dmem_done_q | dmem_resp_i) : 1'b0;
        state_d     = mstall ? MSTALL : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_done_q | dmem_done_q) || (state_q == MSTALL))
                else $error("hazard_ctrl: done flag held outside MSTALL");
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mstall),
        .count (stall_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_bubble),
        .count (bubble_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_flush),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table plus multi-cycle stall, reset and wrap sequences.
module tb_hazard_ctrl;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_reg id_rs1, id_rs2, ex_rd;
    logic use1, use2, mr, br, ird, irsp, dreq, drsp;

    logic pc_l, ifid_l, idex_l, exmem_l, memwb_l, ifid_f, idex_f, cap, imask, dmask;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
    logic w_pc_l, w_ifid_l, w_idex_l, w_exmem_l, w_memwb_l, w_ifid_f, w_idex_f, w_cap, w_imask, w_dmask;
    logic [2:0] w_stall_cnt, w_bubble_cnt, w_flush_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .ID_use_rs1_i(use1), .ID_use_rs2_i(use2),
        .EX_rd_i(ex_rd), .EX_mem_read_i(mr), .EX_br_taken_i(br),
        .imem_read_i(ird), .imem_resp_i(irsp), .dmem_req_i(dreq), .dmem_resp_i(drsp),
        .pc_load_o(pc_l), .IF_ID_load_o(ifid_l), .ID_EX_load_o(idex_l),
        .EX_MEM_load_o(exmem_l), .MEM_WB_load_o(memwb_l),
        .IF_ID_flush_o(ifid_f), .ID_EX_flush_o(idex_f), .imem_capture_o(cap),
        .imem_mask_o(imask), .dmem_mask_o(dmask),
        .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
    );

    // Narrow-counter instance so wrap-around is reachable in a few cycles.
    hazard_ctrl #(.CNT_W(3)) dut_w (
        .clk(clk), .rst(rst),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2), .ID_use_rs1_i(use1), .ID_use_rs2_i(use2),
        .EX_rd_i(ex_rd), .EX_mem_read_i(mr), .EX_br_taken_i(br),
        .imem_read_i(ird), .imem_resp_i(irsp), .dmem_req_i(dreq), .dmem_resp_i(drsp),
        .pc_load_o(w_pc_l), .IF_ID_load_o(w_ifid_l), .ID_EX_load_o(w_idex_l),
        .EX_MEM_load_o(w_exmem_l), .MEM_WB_load_o(w_memwb_l),
        .IF_ID_flush_o(w_ifid_f), .ID_EX_flush_o(w_idex_f), .imem_capture_o(w_cap),
        .imem_mask_o(w_imask), .dmem_mask_o(w_dmask),
        .stall_cnt_o(w_stall_cnt), .bubble_cnt_o(w_bubble_cnt), .flush_cnt_o(w_flush_cnt)
    );

    // Expected bits: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, capture, imask, dmask}
    localparam logic [9:0] E_RUN = 10'b11111_00_0_00;
    localparam logic [9:0] E_STL = 10'b00000_00_0_00;
    localparam logic [9:0] E_BUB = 10'b00111_01_0_00;
    localparam logic [9:0] E_BR  = 10'b11111_11_0_00;

    typedef struct {
        string    name;
        rv32i_reg rd;
        logic     mr;
        rv32i_reg rs1;
        logic     u1;
        rv32i_reg rs2;
        logic     u2;
        logic     br, ird, irsp, dreq, drsp;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_stall, exp_bub, exp_fl;

    function automatic vec_t mk(input string n, input logic [4:0] rd, input logic m,
                                input logic [4:0] r1, input logic a1, input logic [4:0] r2,
                                input logic a2, input logic b, input logic ir, input logic irs,
                                input logic dr, input logic drs, input logic [9:0] e);
        vec_t v;
        v.name = n; v.rd = rd; v.mr = m; v.rs1 = r1; v.u1 = a1; v.rs2 = r2; v.u2 = a2;
        v.br = b; v.ird = ir; v.irsp = irs; v.dreq = dr; v.drsp = drs; v.exp = e;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [9:0] act, wact;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act  = {pc_l, ifid_l, idex_l, exmem_l, memwb_l, ifid_f, idex_f, cap, imask, dmask};
            wact = {w_pc_l, w_ifid_l, w_idex_l, w_exmem_l, w_memwb_l, w_ifid_f, w_idex_f,
                    w_cap, w_imask, w_dmask};
            checks += 2;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: outputs got %b want %b", e.name, act, e.exp);
            end
            if (wact !== e.exp) begin
                failures++;
                $display("FAIL %s_w3: outputs got %b want %b", e.name, wact, e.exp);
            end
        end
    end

    task automatic chk_eq(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        chk_eq({tag, "_stall"}, stall_cnt, exp_stall);
        chk_eq({tag, "_bubble"}, bubble_cnt, exp_bub);
        chk_eq({tag, "_flush"}, flush_cnt, exp_fl);
        chk_eq({tag, "_stall_w3"}, 32'(w_stall_cnt), 32'(exp_stall[2:0]));
        chk_eq({tag, "_bubble_w3"}, 32'(w_bubble_cnt), 32'(exp_bub[2:0]));
        chk_eq({tag, "_flush_w3"}, 32'(w_flush_cnt), 32'(exp_fl[2:0]));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input vec_t v, input bit chk);
        ex_rd = v.rd; mr = v.mr; id_rs1 = v.rs1; use1 = v.u1; id_rs2 = v.rs2; use2 = v.u2;
        br = v.br; ird = v.ird; irsp = v.irsp; dreq = v.dreq; drsp = v.drsp;
        if (chk) begin
            sb.push_back('{v.name, v.exp});
            if (!v.exp[9] && !v.exp[7]) exp_stall++;
            if (v.exp[4]) exp_fl++;
            else if (v.exp[3]) exp_bub++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(mk("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN), 1'b0);
        rst = 1'b0;
        exp_stall = 0; exp_bub = 0; exp_fl = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        exp_stall = 0; exp_bub = 0; exp_fl = 0;
        @(posedge clk);
        #1;
        do_reset();

        chk_eq("rst_state", 32'(dut.state_q), 32'(RUN));
        chk_eq("rst_imask", 32'(imask), 0);
        chk_eq("rst_dmask", 32'(dmask), 0);
        check_cnts("rst");

        //            name           rd mr rs1 u1 rs2 u2 br ird irsp dreq drsp exp
        tbl[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[1]  = mk("lu_rs1_x5",     5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, E_BUB);
        tbl[2]  = mk("run_after_lu",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[3]  = mk("lu_x0",         0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[4]  = mk("lu_rs2_x7",     7, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0, E_BUB);
        tbl[5]  = mk("rs2_unused",    7, 1, 3, 1, 7, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[6]  = mk("alu_dep",       5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN);
        tbl[7]  = mk("br_and_lu",     5, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, E_BR);
        tbl[8]  = mk("br_only",       0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, E_BR);
        tbl[9]  = mk("imem_miss",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL);
        tbl[10] = mk("dmem_miss_br",  0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, E_STL);
        tbl[11] = mk("imem_hit",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E_RUN);
        tbl[12] = mk("lu_dmem_miss",  5, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, E_STL);
        tbl[13] = mk("lu_dmem_resp",  5, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, E_BUB);
        tbl[14] = mk("both_resp",     0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, E_RUN);
        tbl[15] = mk("lu_rs2_only",   5, 1, 6, 1, 5, 1, 0, 0, 0, 0, 0, E_BUB);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i], 1'b1);
            if (i == 1) chk_eq("lu_bubble_cnt", bubble_cnt, 1);
            if (i == 7) chk_eq("br_lu_bubble_cnt", bubble_cnt, 2);
        end
        check_cnts("table");

        // Split responses: imem at cycle 2, dmem at cycle 5.
        do_reset();
        step(mk("r037_c0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_STL), 1'b1);
        step(mk("r037_c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_STL), 1'b1);
        step(mk("r037_c2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 10'b00000_00_1_00), 1'b1);
        step(mk("r037_c3", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10'b00000_00_0_10), 1'b1);
        step(mk("r037_c4", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10'b00000_00_0_10), 1'b1);
        step(mk("r037_c5", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 10'b11111_00_0_10), 1'b1);
        chk_eq("r037_stall_cnt", stall_cnt, 5);
        step(mk("r037_c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN), 1'b1);
        check_cnts("r037");

        // Branch held under an imem stall is taken exactly once on release.
        step(mk("br_held_0", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, E_STL), 1'b1);
        step(mk("br_held_1", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, E_STL), 1'b1);
        step(mk("br_release", 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, E_BR), 1'b1);
        step(mk("br_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN), 1'b1);
        check_cnts("br_held");

        // Reset in the third cycle of a stall with the dmem response already flagged.
        do_reset();
        step(mk("rst_mid_c0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_STL), 1'b1);
        step(mk("rst_mid_c1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, E_STL), 1'b1);
        chk_eq("rst_mid_pre_state", 32'(dut.state_q), 32'(MSTALL));
        chk_eq("rst_mid_pre_dmask", 32'(dmask), 1);
        chk_eq("rst_mid_pre_stall", stall_cnt, 2);
        rst = 1'b1;
        step(mk("rst_mid_c2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, E_STL), 1'b0);
        rst = 1'b0;
        exp_stall = 0; exp_bub = 0; exp_fl = 0;
        chk_eq("rst_mid_state", 32'(dut.state_q), 32'(RUN));
        chk_eq("rst_mid_imask", 32'(imask), 0);
        chk_eq("rst_mid_dmask", 32'(dmask), 0);
        check_cnts("rst_mid");

        // Counter wrap on the 3-bit instance: 7 stalls, then one more returns to 0.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(mk("wrap_stall", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL), 1'b1);
        end
        chk_eq("wrap_pre", 32'(w_stall_cnt), 7);
        step(mk("wrap_stall", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E_STL), 1'b1);
        chk_eq("wrap_zero", 32'(w_stall_cnt), 0);
        check_cnts("wrap");

        step(mk("final_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN), 1'b1);
        chk_eq("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of each performance counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ID_rs1_i, ID_rs2_i  in  rv32i_reg  source registers of the instruction in ID.
REQ-005 ID_use_rs1_i, ID_use_rs2_i  in  1  ID instruction actually reads rs1 / rs2.
REQ-006 EX_rd_i  in  rv32i_reg  destination of the instruction in EX.
REQ-007 EX_mem_read_i  in  1  EX instruction is a load.
REQ-008 EX_br_taken_i  in  1  branch/jump resolved taken in EX.
REQ-009 imem_read_i, imem_resp_i  in  1  instruction-memory request / response.
REQ-010 dmem_req_i, dmem_resp_i  in  1  data-memory request (read or write) from MEM / response.
REQ-011 pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o  out  1  register enables.
REQ-012 IF_ID_flush_o, ID_EX_flush_o  out  1  replace register contents with a NOP bubble on the load edge.
REQ-013 imem_capture_o  out  1  IF latches the returning instruction into its holding register.
REQ-014 imem_mask_o, dmem_mask_o  out  1  requester deasserts its request; response already received.
REQ-015 stall_cnt_o, bubble_cnt_o, flush_cnt_o  out  CNT_W  performance counters.

Function
REQ-016 imem_busy = imem_read_i & ~imem_resp_i & ~imem_done_q; dmem_busy = dmem_req_i & ~dmem_resp_i & ~dmem_done_q; mstall = imem_busy | dmem_busy.
REQ-017 load_use = EX_mem_read_i & |EX_rd_i & ((ID_use_rs1_i & EX_rd_i==ID_rs1_i) | (ID_use_rs2_i & EX_rd_i==ID_rs2_i)).
REQ-018 Priority, highest first: mstall, EX_br_taken_i, load_use, run.
REQ-019 mstall: all five load enables 0, both flushes 0.
REQ-020 Branch (no mstall): all loads 1; IF_ID_flush_o=1, ID_EX_flush_o=1; load_use ignored.
REQ-021 Load-use (no mstall, no branch): pc_load_o=0, IF_ID_load_o=0, ID_EX_load_o=1 with ID_EX_flush_o=1; EX_MEM and MEM_WB load 1; exactly one bubble per load.
REQ-022 Run: all loads 1, flushes 0.
REQ-023 Outputs combinational from inputs and registered state; zero-cycle latency.
REQ-024 imem_done_q set on the edge where mstall=1 & imem_resp_i=1; cleared on any edge where mstall=0. dmem_done_q is the same with dmem_resp_i.
REQ-025 imem_capture_o = mstall & imem_resp_i; imem_mask_o = imem_done_q; dmem_mask_o = dmem_done_q.
REQ-026 Both responses arriving in the same cycle: mstall=0, no flag set, pipeline advances that cycle.
REQ-027 FSM states RUN, MSTALL. RUN->MSTALL when mstall; MSTALL->RUN when ~mstall; state drives no enables and exists for the counters and assertions.
REQ-028 stall_cnt increments each cycle mstall=1; bubble_cnt increments each cycle REQ-021 applies; flush_cnt increments each cycle REQ-020 applies. All wrap modulo 2^CNT_W.
REQ-029 Branch and load_use held under mstall are re-evaluated each cycle; nothing is lost or double-counted when the stall releases.

Reset
REQ-030 On rst: state=RUN, imem_done_q=0, dmem_done_q=0, all counters 0; rst overrides all other updates, including mid-stall.
REQ-031 During rst, outputs follow REQ-016..025 with flags cleared; no separate reset value forced on the enables.

Structure
REQ-032 hazard_state_t enum {RUN, MSTALL} placed in rv32i_types package, in a hazard namespace like forwardingmux.
REQ-033 Counters are implemented as a sub-module perf_counter (parameter CNT_W, inputs clk, rst, inc; output count), instantiated three times.
REQ-034 Forwarding selection is out of scope; this block only stalls, flushes, and masks.

Verification
REQ-035 EX load rd=x5, ID rs1=x5 use_rs1=1, no mem traffic -> one cycle with pc_load=0, IF_ID_load=0, ID_EX_flush=1; bubble_cnt 0->1; next cycle run.
REQ-036 EX load rd=x0, ID rs1=x0 -> no bubble; all loads 1.
REQ-037 imem_read=1 and dmem_req=1; imem_resp at cycle 2, dmem_resp at cycle 5 -> loads 0 for cycles 0-4; imem_capture=1 at cycle 2; imem_mask=1 for cycles 3-5; advance at cycle 5; stall_cnt=5.
REQ-038 EX_br_taken=1 and load_use=1 together -> both flushes 1, pc_load=1; flush_cnt+1, bubble_cnt unchanged.
REQ-039 rst asserted during cycle 3 of a dmem stall -> next cycle imem_done_q=dmem_done_q=0, counters 0, state RUN.
REQ-040 Force stall_cnt to 2^32-1 and add one stall cycle -> stall_cnt=0.
